// File: rtl/bus_arb_rr4_if.sv
// Request/bus handshake bundle between the four requester queues, the memory bus and the arbiter.
// slave = arbiter side, master = requesters/bus side.
interface bus_arb_rr4_if;
  logic [3:0] req;
  logic       bus_gnt;
  logic       bus_done;
  logic       bus_req;
  logic [1:0] owner;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       err;
  logic       busy;

  modport slave  (input  req, bus_gnt, bus_done,
                  output bus_req, owner, gnt, done, err, busy);
  modport master (output req, bus_gnt, bus_done,
                  input  bus_req, owner, gnt, done, err, busy);
endinterface

// File: rtl/bus_arb_rr4.sv
// Round-robin arbiter sharing one memory-bus port among four request queues.
// Runs the bus_req/bus_gnt/bus_done handshake for the winner; all outputs registered.
module bus_arb_rr4 #(
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15
) (
  input  logic          i_clk,
  input  logic          i_rst,
  bus_arb_rr4_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    XFER = 2'b10
  } state_t;

  state_t           r_state, w_nstate;
  logic [1:0]       r_ptr, w_nptr;
  logic [1:0]       r_owner, w_nowner;
  logic [TMO_W-1:0] r_tmo, w_ntmo;
  logic             r_bus_req, w_nbus_req;
  logic [3:0]       r_gnt, w_ngnt;
  logic [3:0]       r_done, w_ndone;
  logic             r_err, w_nerr;
  logic             r_busy;

  logic [1:0]       w_win;
  logic             w_found;
  logic [3:0]       w_own_oh;

  // First requester at or after the pointer, wrapping mod 4
  always_comb begin
    logic [1:0] idx;
    w_win   = '0;
    w_found = 1'b0;
    idx     = '0;
    for (int i = 0; i < 4; i++) begin
      idx = r_ptr + 2'(i);
      if (!w_found && bus.req[idx]) begin
        w_win   = idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_own_oh = 4'b0001 << r_owner;

  always_comb begin
    w_nstate   = r_state;
    w_nptr     = r_ptr;
    w_nowner   = r_owner;
    w_ntmo     = r_tmo;
    w_nbus_req = 1'b0;
    w_ngnt     = '0;
    w_ndone    = '0;
    w_nerr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nstate   = REQ;
          w_nowner   = w_win;
          w_nbus_req = 1'b1;
        end
      end
      REQ: begin
        // Grant beats a same-cycle withdrawal
        if (bus.bus_gnt) begin
          w_nstate = XFER;
          w_ntmo   = '0;
          w_ngnt   = w_own_oh;
        end else if (!bus.req[r_owner]) begin
          w_nstate = IDLE;
        end else begin
          w_nbus_req = 1'b1;
        end
      end
      XFER: begin
        if (bus.bus_done) begin
          w_nstate = IDLE;
          w_ndone  = w_own_oh;
          w_nptr   = r_owner + 2'd1;
        end else if (r_tmo == TMO_W'(TMO_MAX)) begin
          w_nstate = IDLE;
          w_nerr   = 1'b1;
          w_nptr   = r_owner + 2'd1;
        end else begin
          w_ntmo = r_tmo + 1'b1;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_tmo     <= '0;
      r_bus_req <= 1'b0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_ptr     <= w_nptr;
      r_owner   <= w_nowner;
      r_tmo     <= w_ntmo;
      r_bus_req <= w_nbus_req;
      r_gnt     <= w_ngnt;
      r_done    <= w_ndone;
      r_err     <= w_nerr;
      r_busy    <= (w_nstate == REQ) || (w_nstate == XFER);
    end
  end

  assign bus.bus_req = r_bus_req;
  assign bus.owner   = r_owner;
  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_bus_arb_rr4.sv
// Directed bench for bus_arb_rr4: reset, single transfer, rotation, timeout, withdrawal,
// grant/done priority and reset during a transfer.
module tb_bus_arb_rr4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_arb_rr4_if ifc ();

  bus_arb_rr4 #(.TMO_W(4), .TMO_MAX(15)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable for the new cycle and new inputs apply to its end.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ifc.req = '0; ifc.bus_gnt = 1'b0; ifc.bus_done = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ifc.req = 4'hF; ifc.bus_gnt = 1'b1; ifc.bus_done = 1'b1;
    step(); step();
    n_cmp++; if ({ifc.bus_req, ifc.owner, ifc.gnt, ifc.done, ifc.err, ifc.busy} !== 13'h0) begin
      n_bad++; $display("FAIL reset_outs: got %h want 0", {ifc.bus_req, ifc.owner, ifc.gnt, ifc.done, ifc.err, ifc.busy}); end
    rst = 1'b1; ifc.bus_gnt = 1'b0; ifc.bus_done = 1'b0;
    step();
    n_cmp++; if ({ifc.bus_req, ifc.busy, ifc.owner} !== 4'b1100) begin
      n_bad++; $display("FAIL reset_release: got bus_req/busy/owner %b want 1100", {ifc.bus_req, ifc.busy, ifc.owner}); end
    ifc.req = '0;
    step();
    n_cmp++; if ({ifc.bus_req, ifc.busy, ifc.gnt} !== 6'b0) begin
      n_bad++; $display("FAIL reset_withdraw: got %b want 0", {ifc.bus_req, ifc.busy, ifc.gnt}); end
  endtask

  task automatic test_single();
    do_reset();
    ifc.req = 4'b0100;                           // t0
    step();                                      // t1
    n_cmp++; if ({ifc.bus_req, ifc.busy, ifc.owner, ifc.gnt} !== 8'b1110_0000) begin
      n_bad++; $display("FAIL single_t1: got %b want 11100000", {ifc.bus_req, ifc.busy, ifc.owner, ifc.gnt}); end
    step();                                      // t2
    n_cmp++; if ({ifc.bus_req, ifc.busy} !== 2'b11) begin
      n_bad++; $display("FAIL single_t2: got %b want 11", {ifc.bus_req, ifc.busy}); end
    ifc.bus_gnt = 1'b1;
    step();                                      // t3
    n_cmp++; if ({ifc.gnt, ifc.bus_req, ifc.busy, ifc.done} !== 10'b0100_0_1_0000) begin
      n_bad++; $display("FAIL single_t3: got %b want 0100010000", {ifc.gnt, ifc.bus_req, ifc.busy, ifc.done}); end
    ifc.bus_gnt = 1'b0; ifc.req = '0;
    step();                                      // t4
    n_cmp++; if ({ifc.gnt, ifc.busy, ifc.done} !== 9'b0000_1_0000) begin
      n_bad++; $display("FAIL single_t4: got %b want 000010000", {ifc.gnt, ifc.busy, ifc.done}); end
    ifc.bus_done = 1'b1;
    step();                                      // t5
    n_cmp++; if ({ifc.done, ifc.busy, ifc.err, ifc.gnt} !== 10'b0100_0_0_0000) begin
      n_bad++; $display("FAIL single_t5: got %b want 0100000000", {ifc.done, ifc.busy, ifc.err, ifc.gnt}); end
    ifc.bus_done = 1'b0;
    step();                                      // t6
    n_cmp++; if ({ifc.done, ifc.busy, ifc.bus_req} !== 6'b0) begin
      n_bad++; $display("FAIL single_t6: got %b want 0", {ifc.done, ifc.busy, ifc.bus_req}); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_own [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    ifc.req = 4'hF; ifc.bus_gnt = 1'b1; ifc.bus_done = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({ifc.bus_req, ifc.owner} !== {1'b1, exp_own[k]}) begin
        n_bad++; $display("FAIL rot_req[%0d]: got bus_req/owner %b want %b", k, {ifc.bus_req, ifc.owner}, {1'b1, exp_own[k]}); end
      step();
      n_cmp++; if (ifc.gnt !== (4'b0001 << exp_own[k])) begin
        n_bad++; $display("FAIL rot_gnt[%0d]: got %b want %b", k, ifc.gnt, 4'b0001 << exp_own[k]); end
      step();
      n_cmp++; if ({ifc.done, ifc.busy} !== {4'b0001 << exp_own[k], 1'b0}) begin
        n_bad++; $display("FAIL rot_idle[%0d]: got done/busy %b want %b", k, {ifc.done, ifc.busy}, {4'b0001 << exp_own[k], 1'b0}); end
      step();
    end
    ifc.req = '0; ifc.bus_gnt = 1'b0; ifc.bus_done = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_timeout();
    do_reset();
    ifc.req = 4'b0010;
    step();
    ifc.bus_gnt = 1'b1;
    step();                                      // XFER cycle 1
    ifc.bus_gnt = 1'b0;
    n_cmp++; if (ifc.gnt !== 4'b0010) begin
      n_bad++; $display("FAIL tmo_gnt: got %b want 0010", ifc.gnt); end
    for (int c = 2; c <= 16; c++) begin
      step();
      n_cmp++; if ({ifc.err, ifc.busy} !== 2'b01) begin
        n_bad++; $display("FAIL tmo_wait[%0d]: got err/busy %b want 01", c, {ifc.err, ifc.busy}); end
    end
    step();
    n_cmp++; if ({ifc.err, ifc.busy, ifc.owner, ifc.done} !== 8'b1_0_01_0000) begin
      n_bad++; $display("FAIL tmo_err: got %b want 10010000", {ifc.err, ifc.busy, ifc.owner, ifc.done}); end
    ifc.req = 4'b1011;                           // search from 2 -> 3
    step();
    n_cmp++; if ({ifc.err, ifc.owner, ifc.bus_req} !== 4'b0111) begin
      n_bad++; $display("FAIL tmo_next: got err/owner/bus_req %b want 0111", {ifc.err, ifc.owner, ifc.bus_req}); end
    ifc.req = '0;
    step();
  endtask

  task automatic test_withdraw();
    do_reset();
    ifc.req = 4'b1000;
    step();
    n_cmp++; if ({ifc.bus_req, ifc.owner} !== 3'b111) begin
      n_bad++; $display("FAIL wd_req: got %b want 111", {ifc.bus_req, ifc.owner}); end
    ifc.req = '0;
    step();
    n_cmp++; if ({ifc.bus_req, ifc.busy, ifc.gnt} !== 6'b0) begin
      n_bad++; $display("FAIL wd_drop: got %b want 0", {ifc.bus_req, ifc.busy, ifc.gnt}); end
    ifc.req = 4'hF;                              // ptr still 0
    step();
    n_cmp++; if ({ifc.bus_req, ifc.owner} !== 3'b100) begin
      n_bad++; $display("FAIL wd_ptr: got %b want 100", {ifc.bus_req, ifc.owner}); end
    ifc.req = '0;
    step();
  endtask

  task automatic test_priority();
    do_reset();
    ifc.req = 4'b0100;
    step();
    ifc.req = '0; ifc.bus_gnt = 1'b1;            // grant beats withdrawal
    step();
    ifc.bus_gnt = 1'b0;
    n_cmp++; if ({ifc.gnt, ifc.busy} !== 5'b0100_1) begin
      n_bad++; $display("FAIL prio_gnt: got %b want 01001", {ifc.gnt, ifc.busy}); end
    for (int c = 2; c <= 16; c++) step();        // now in XFER cycle 16 (tmo==15)
    ifc.bus_done = 1'b1;                         // done beats timeout
    step();
    ifc.bus_done = 1'b0;
    n_cmp++; if ({ifc.done, ifc.err, ifc.busy} !== 6'b0100_0_0) begin
      n_bad++; $display("FAIL prio_done: got %b want 010000", {ifc.done, ifc.err, ifc.busy}); end
    step();
  endtask

  task automatic test_reset_xfer();
    do_reset();
    ifc.req = 4'b0001;
    step();
    ifc.bus_gnt = 1'b1;
    step();
    ifc.bus_gnt = 1'b0; ifc.req = '0;
    ifc.bus_done = 1'b1; rst = 1'b0;
    step();
    n_cmp++; if ({ifc.bus_req, ifc.owner, ifc.gnt, ifc.done, ifc.err, ifc.busy} !== 13'h0) begin
      n_bad++; $display("FAIL rstx_outs: got %h want 0", {ifc.bus_req, ifc.owner, ifc.gnt, ifc.done, ifc.err, ifc.busy}); end
    rst = 1'b1; ifc.bus_done = 1'b0; ifc.req = 4'b1001;   // ptr 0 -> owner 0
    step();
    n_cmp++; if ({ifc.bus_req, ifc.owner, ifc.done} !== 7'b1_00_0000) begin
      n_bad++; $display("FAIL rstx_ptr: got %b want 1000000", {ifc.bus_req, ifc.owner, ifc.done}); end
    ifc.req = '0;
    step();
  endtask

  initial begin
    ifc.req = '0; ifc.bus_gnt = 1'b0; ifc.bus_done = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_withdraw();
    test_priority();
    test_reset_xfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
